// File: rtl/serial_adder_unit.sv
// -----------------------------------------------------------------------------
// serial_adder_unit
//
// Bit-serial WIDTH-bit adder for the Mini 8-bit CPU datapath. A start pulse
// latches both operands and the carry-in. One bit per clock then passes
// LSB-first through a single FullAdder, with the carry held in a flip-flop
// between bits. The finished sum goes to registered outputs together with
// carry, zero and signed-overflow flags and a one-cycle done pulse.
//
// Optional feature macro: SERIAL_SUB_EN
//   defined   -> adds the `sub` port. Subtraction is A + ~B + 1.
//   undefined -> add only. No `sub` port, no B inversion, no sub register.
//
// Parameters
//   WIDTH   operand/result width, 2..32 (default 8)
//
// Ports
//   clk     rising-edge clock
//   rst_n   synchronous active-low reset; clears state and all outputs
//   start   request an operation (sampled only in IDLE)
//   op_a    operand A, latched on accepted start
//   op_b    operand B, latched on accepted start
//   cin     carry-in, latched on accepted start (ignored when subtracting)
//   sub     subtract select (SERIAL_SUB_EN only), latched on accepted start
//   busy    high while SHIFT or DONE
//   done    one-cycle pulse when result and flags become valid
//   result  sum or difference
//   cout    final carry (in subtract mode, 1 = no borrow)
//   zero    result == 0
//   ovf     signed two's-complement overflow
// -----------------------------------------------------------------------------

module FullAdder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sum,
   output logic cout
);
   assign sum  = a ^ b ^ cin;
   assign cout = (a & b) | (a & cin) | (b & cin);
endmodule

module serial_adder_unit #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   input  logic             cin,
`ifdef SERIAL_SUB_EN
   input  logic             sub,
`endif
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             cout,
   output logic             zero,
   output logic             ovf
);

   localparam int CNT_W = $clog2(WIDTH);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_next;

   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_acc;      // partial sums stay here, never on result
   logic             r_carry;
   logic [CNT_W-1:0] r_cnt;

   logic             r_busy;
   logic             r_done;
   logic [WIDTH-1:0] r_result;
   logic             r_cout;
   logic             r_zero;
   logic             r_ovf;

   logic             w_last;
   logic             w_b_bit;
   logic             w_init_carry;
   logic             w_sum;
   logic             w_cout;
   logic [WIDTH-1:0] w_acc_next;

`ifdef SERIAL_SUB_EN
   logic             r_sub;

   // Subtract is A + ~B + 1: invert B serially and force the initial carry.
   assign w_b_bit      = r_b[0] ^ r_sub;
   assign w_init_carry = sub | cin;
`else
   assign w_b_bit      = r_b[0];
   assign w_init_carry = cin;
`endif

   FullAdder u_fa (
      .a    (r_a[0]),
      .b    (w_b_bit),
      .cin  (r_carry),
      .sum  (w_sum),
      .cout (w_cout)
   );

   assign w_last     = (r_cnt == CNT_W'(WIDTH - 1));
   assign w_acc_next = {w_sum, r_acc[WIDTH-1:1]};

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   // Next-state logic
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (start)  w_next = S_SHIFT;
         S_SHIFT: if (w_last) w_next = S_DONE;
         S_DONE:              w_next = S_IDLE;
         default:             w_next = S_IDLE;
      endcase
   end

   // Datapath and registered outputs
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_a      <= '0;
         r_b      <= '0;
         r_acc    <= '0;
         r_carry  <= 1'b0;
         r_cnt    <= '0;
`ifdef SERIAL_SUB_EN
         r_sub    <= 1'b0;
`endif
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_result <= '0;
         r_cout   <= 1'b0;
         r_zero   <= 1'b0;
         r_ovf    <= 1'b0;
      end else begin
         r_busy <= (w_next != S_IDLE);
         r_done <= (w_next == S_DONE);
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_a     <= op_a;
                  r_b     <= op_b;
                  r_carry <= w_init_carry;
                  r_cnt   <= '0;
`ifdef SERIAL_SUB_EN
                  r_sub   <= sub;
`endif
               end
            end
            S_SHIFT: begin
               r_a     <= {1'b0, r_a[WIDTH-1:1]};
               r_b     <= {1'b0, r_b[WIDTH-1:1]};
               r_acc   <= w_acc_next;
               r_carry <= w_cout;
               r_cnt   <= r_cnt + CNT_W'(1);
               if (w_last) begin
                  // r_carry here is the carry into the MSB (c_msb).
                  r_result <= w_acc_next;
                  r_cout   <= w_cout;
                  r_zero   <= ~|w_acc_next;
                  r_ovf    <= r_carry ^ w_cout;
               end
            end
            default: ;
         endcase
      end
   end

   assign busy   = r_busy;
   assign done   = r_done;
   assign result = r_result;
   assign cout   = r_cout;
   assign zero   = r_zero;
   assign ovf    = r_ovf;

endmodule

// File: doc/serial_adder_unit.md
# serial_adder_unit

Bit-serial WIDTH-bit adder stage for the Mini 8-bit CPU datapath. It accepts two operands with a start pulse, shifts them LSB-first through a single instantiated `FullAdder`, one bit per clock, and holds the carry in a flip-flop between bits. It assembles the sum in a shift register and reports the result with carry, zero and signed-overflow flags and a done pulse. It sits directly upstream of `FullAdder`, driving its `a`, `b` and `cin` inputs and consuming its `sum` and `cout` outputs, and it presents the finished result to the ALU/accumulator.

## Interface
Parameters:
- `WIDTH`, default 8. Operand and result width in bits; legal values are 2 to 32.

Ports:
- `clk`, input, 1 bit. Single clock; all state updates on the rising edge.
- `rst_n`, input, 1 bit. Reset, synchronous and active-low.
- `start`, input, 1 bit. Request a new operation; sampled only in IDLE.
- `op_a`, input, WIDTH bits. Operand A; latched when start is accepted.
- `op_b`, input, WIDTH bits. Operand B; latched when start is accepted.
- `cin`, input, 1 bit. Carry-in for addition; latched when start is accepted.
- `sub`, input, 1 bit. Selects subtract. This port exists only with `SERIAL_SUB_EN`.
- `busy`, output, 1 bit. High in SHIFT and DONE states.
- `done`, output, 1 bit. One-cycle pulse marking a valid result.
- `result`, output, WIDTH bits. Sum or difference.
- `cout`, output, 1 bit. Final carry. In subtract mode, 1 means no borrow.
- `zero`, output, 1 bit. Set when `result` is 0.
- `ovf`, output, 1 bit. Signed two's-complement overflow.

## Operation
- FSM states are IDLE, SHIFT and DONE.
- **IDLE to SHIFT** when `start`=1:
  - `op_a` loads into shift register A and `op_b` into shift register B.
  - The carry flip-flop loads `cin`, or 1 when subtracting.
  - The bit counter clears to 0.
- **SHIFT:**
  - The FullAdder inputs are `a`=A[0], `b`=B[0] XOR sub_latched, and `cin`=the carry flip-flop.
  - Each edge shifts `sum` into the result register at the MSB, shifting right.
  - A and B shift right, the carry flip-flop takes `cout`, and the counter increments.
  - The carry value presented on the MSB bit (counter = WIDTH-1) is saved as c_msb.
- **SHIFT to DONE** on the edge that processes bit WIDTH-1.
- **DONE to IDLE** unconditionally on the next edge.
- Flag rules:
  - `cout` is the final carry flip-flop value.
  - `ovf` is c_msb XOR the final carry.
  - `zero` is the NOR of `result`.
- Arithmetic is modulo 2^WIDTH. Subtraction is A + ~B + 1.
- `result`, `cout`, `zero` and `ovf` update only when entering DONE. They then hold until the next accepted start enters DONE.
- `result` must not show partial sums; a separate internal shift register is used for accumulation.
- `start` is ignored in SHIFT and DONE, with no queuing. Operand and `sub` changes after acceptance have no effect.
- Reset (`rst_n`=0 at an edge), including mid-operation:
  - State goes to IDLE and the operation is discarded.
  - `busy`, `done`, `result`, `cout`, `zero` and `ovf` all become 0.
  - Shift registers and the counter clear.
  - Reset takes priority over `start`.

## Timing
- Start is accepted at edge E0.
- `busy` rises after E0.
- Bits 0 to WIDTH-1 are processed at edges E1 to E_WIDTH.
- `done`=1 and the flags are valid in the cycle after E_WIDTH. For WIDTH=8, this is 9 cycles after start is sampled.
- `busy` falls after E_WIDTH+1.
- The earliest next start is accepted at E_WIDTH+2, which gives a throughput of one operation per WIDTH+2 cycles.
- `done` is exactly one cycle wide and never asserts without a preceding accepted start.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Configuration
- `SERIAL_SUB_EN` is defined:
  - The `sub` port exists and is latched at start.
  - `sub`=1 inverts B bits and forces the initial carry to 1, so `cin` is ignored.
- `SERIAL_SUB_EN` is undefined:
  - There is no `sub` port and the unit adds only.
  - The initial carry is always `cin`.
  - No XOR and no sub register are synthesized.

## Test plan
- WIDTH=8, `op_a`=0x3C, `op_b`=0x0F, `cin`=0, start -> `done` 9 cycles later with `result`=0x4B, `cout`=0, `zero`=0, `ovf`=0.
- `op_a`=0xFF, `op_b`=0x01, `cin`=0 -> `result`=0x00, `cout`=1, `zero`=1, `ovf`=0. Then 0x7F+0x01 -> `result`=0x80, `cout`=0, `ovf`=1.
- With `SERIAL_SUB_EN`: `sub`=1, 0x05-0x07 -> `result`=0xFE, `cout`=0, `ovf`=0. Then 0x80-0x01 -> `result`=0x7F, `cout`=1, `ovf`=1.
- Start 0x10+0x20, then pulse start with 0xAA+0x55 at cycles 3 and 9 -> both ignored. A single `done` with `result`=0x30, and `busy` stays high throughout.
- Start 0x3C+0x0F, then `rst_n`=0 for one cycle after 4 shift edges -> all outputs 0 next cycle, no `done`. A new start of 0x01+0x01 then gives `result`=0x02 exactly 9 cycles later.
